// File: rtl/banked_byte_ram.sv
// banked_byte_ram: big-endian byte-addressed word RAM split into banks.
// Bank-crossing accesses take two cycles; a clear sequence runs after reset.
module banked_byte_ram #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 11,
  parameter int BANK_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  input  logic [WORD_BYTES-1:0]   req_be,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    init_done
);

  localparam int DW    = 8*WORD_BYTES;
  localparam int NBANK = 2**BANK_BITS;
  localparam int ROW_W = ADDR_W-BANK_BITS;
  localparam int ROWS  = 2**ROW_W;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SECOND
  } state_e;

  state_e state_q, state_d;
  logic [ROW_W-1:0] clr_cnt_q, clr_cnt_d;
  logic init_done_q, init_done_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_wdata_q, hold_wdata_d;
  logic [WORD_BYTES-1:0] hold_be_q, hold_be_d;
  logic hold_write_q, hold_write_d;
  logic [DW-1:0] part_q, part_d;

  logic [7:0] mem_q [NBANK][ROWS];

  logic [ADDR_W-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [WORD_BYTES-1:0] cur_be;
  logic cur_write;
  logic [BANK_BITS-1:0] base_bank;
  logic [ADDR_W:0] lane_addr [WORD_BYTES];
  logic [BANK_BITS-1:0] lane_bank [WORD_BYTES];
  logic [ROW_W-1:0] lane_row [WORD_BYTES];
  logic [WORD_BYTES-1:0] lane_inr;
  logic [WORD_BYTES-1:0] lane_first;
  logic [WORD_BYTES-1:0] lane_sel;
  logic [WORD_BYTES-1:0] lane_we;
  logic [DW-1:0] rd_now;
  logic accept;
  logic need_second;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign accept    = req_valid && (state_q == IDLE);

  // Per-lane address split, bank selection and read of the served lanes
  always_comb begin
    cur_addr  = req_addr;
    cur_wdata = req_wdata;
    cur_be    = req_be;
    cur_write = req_write;
    if (state_q == SECOND) begin
      cur_addr  = hold_addr_q;
      cur_wdata = hold_wdata_q;
      cur_be    = hold_be_q;
      cur_write = hold_write_q;
    end
    base_bank = cur_addr[ADDR_W-1 -: BANK_BITS];
    lane_inr   = '0;
    lane_first = '0;
    lane_sel   = '0;
    lane_we    = '0;
    rd_now     = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_addr[i] = {1'b0, cur_addr} + (ADDR_W+1)'(i);
      lane_bank[i] = lane_addr[i][ADDR_W-1 -: BANK_BITS];
      lane_row[i]  = lane_addr[i][ROW_W-1:0];
      lane_inr[i]  = ~lane_addr[i][ADDR_W];
      lane_first[i] = lane_inr[i] && (lane_bank[i] == base_bank);
    end
    need_second = |(lane_inr & ~lane_first);
    if (accept)
      lane_sel = lane_first;
    else if (state_q == SECOND)
      lane_sel = lane_inr & ~lane_first;
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_we[i] = lane_sel[i] && cur_write
                && cur_be[WORD_BYTES-1-i];
      if (lane_sel[i])
        rd_now[DW-1-8*i -: 8] = mem_q[lane_bank[i]][lane_row[i]];
    end
  end

  // Memory array: row clear across all banks, or byte-lane writes
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int b = 0; b < NBANK; b++)
        mem_q[b][clr_cnt_q] <= 8'h00;
    end else begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (lane_we[i])
          mem_q[lane_bank[i]][lane_row[i]] <=
            cur_wdata[DW-1-8*i -: 8];
    end
  end

  // Next-state, request capture and response assembly
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    hold_write_d = hold_write_q;
    part_d       = part_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ROW_W'(ROWS-1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          if (need_second) begin
            state_d      = SECOND;
            hold_addr_d  = req_addr;
            hold_wdata_d = req_wdata;
            hold_be_d    = req_be;
            hold_write_d = req_write;
            part_d       = rd_now;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_write ? '0 : rd_now;
          end
        end
      end
      SECOND: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = hold_write_q ? '0 : (part_q | rd_now);
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
      hold_write_q <= 1'b0;
      part_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      init_done_q  <= init_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_be_q    <= hold_be_d;
      hold_write_q <= hold_write_d;
      part_q       <= part_d;
    end
  end

endmodule

// File: tb/tb_banked_byte_ram.sv
// tb_banked_byte_ram: randomized bench for banked_byte_ram.
// Expected data comes from a flat byte-array model of the memory.
module tb_banked_byte_ram;

  localparam int WB    = 4;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;
  localparam int BANKB = 256;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [WB-1:0] req_be;
  logic rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic init_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];

  banked_byte_ram dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  function automatic void ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic logic [DW-1:0] ref_read(input int a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < WB; i++)
      if (a + i < DEPTH) r[DW-1-8*i -: 8] = ref_mem[a+i];
    return r;
  endfunction

  function automatic void ref_write(input int a,
                                    input logic [DW-1:0] d,
                                    input logic [WB-1:0] be);
    for (int i = 0; i < WB; i++)
      if (a + i < DEPTH && be[WB-1-i])
        ref_mem[a+i] = d[DW-1-8*i -: 8];
  endfunction

  function automatic int ref_lat(input int a);
    for (int i = 0; i < WB; i++)
      if (a + i < DEPTH && (a + i) / BANKB != a / BANKB) return 2;
    return 1;
  endfunction

  // Drive one request; report response data, latency (0 = none)
  // and req_ready in the cycle after acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [WB-1:0] be,
                       output logic [DW-1:0] rd, output int lat,
                       output logic rdy_after);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rdy_after = req_ready;
    lat = 0;
    rd = 'x;
    for (int k = 1; k <= 4; k++) begin
      if (rsp_valid) begin
        lat = k;
        rd = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 0", rsp_rdata);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done got %b exp 0", init_done);
    end
    rst = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 256) begin
      errors++;
      $display("FAIL clear_cycles got %0d exp 256", cnt);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done got %b exp 1", init_done);
    end
    ref_clear();
    issue(1'b0, 11'h000, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL read_after_clear got %h lat %0d exp 0 lat 1",
               rd, lat);
    end
  endtask

  task automatic test_aligned();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    issue(1'b1, 11'h010, 32'hDEADBEEF, 4'b1111, rd, lat, ra);
    ref_write(16, 32'hDEADBEEF, 4'b1111);
    checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL aligned_wr_rsp got %h lat %0d exp 0 lat 1",
               rd, lat);
    end
    issue(1'b0, 11'h010, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 1) begin
      errors++;
      $display("FAIL aligned_rd got %h lat %0d exp deadbeef lat 1",
               rd, lat);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rsp_hold got v%b %h exp v0 deadbeef",
               rsp_valid, rsp_rdata);
    end
    issue(1'b0, 11'h011, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'hADBEEF00) begin
      errors++;
      $display("FAIL bytes_011 got %h exp adbeef00", rd);
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    issue(1'b1, 11'h010, 32'h11223344, 4'b1010, rd, lat, ra);
    ref_write(16, 32'h11223344, 4'b1010);
    issue(1'b0, 11'h010, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'h11AD33EF) begin
      errors++;
      $display("FAIL byte_enable got %h exp 11ad33ef", rd);
    end
    issue(1'b1, 11'h010, 32'hFFFFFFFF, 4'b0000, rd, lat, ra);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL be_zero_rsp got lat %0d exp 1", lat);
    end
    issue(1'b0, 11'h010, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== ref_read(16)) begin
      errors++;
      $display("FAIL be_zero_data got %h exp %h", rd, ref_read(16));
    end
  endtask

  task automatic test_crossing();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    issue(1'b1, 11'h0FE, 32'hCAFEF00D, 4'b1111, rd, lat, ra);
    ref_write(254, 32'hCAFEF00D, 4'b1111);
    checks++;
    if (lat !== 2 || ra !== 1'b0) begin
      errors++;
      $display("FAIL cross_wr got lat %0d rdy %b exp lat 2 rdy 0",
               lat, ra);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL cross_ready_back got %b exp 1", req_ready);
    end
    issue(1'b0, 11'h0FE, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'hCAFEF00D || lat !== 2) begin
      errors++;
      $display("FAIL cross_rd got %h lat %0d exp cafef00d lat 2",
               rd, lat);
    end
    issue(1'b0, 11'h100, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'hF00D0000 || lat !== 1) begin
      errors++;
      $display("FAIL rd_100 got %h lat %0d exp f00d0000 lat 1",
               rd, lat);
    end
  endtask

  task automatic test_top_edge();
    logic [DW-1:0] rd;
    int lat;
    logic ra;
    issue(1'b1, 11'h7FE, 32'hAABBCCDD, 4'b1111, rd, lat, ra);
    ref_write(2046, 32'hAABBCCDD, 4'b1111);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL top_wr_lat got %0d exp 1", lat);
    end
    issue(1'b0, 11'h7FE, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'hAABB0000 || lat !== 1) begin
      errors++;
      $display("FAIL top_rd got %h lat %0d exp aabb0000 lat 1",
               rd, lat);
    end
    issue(1'b0, 11'h000, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'h00000000) begin
      errors++;
      $display("FAIL no_wrap got %h exp 00000000", rd);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, exp_d, d;
    logic [AW-1:0] a;
    logic [WB-1:0] be;
    logic w, ra;
    int lat, exp_lat;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        a = AW'($urandom_range(0, 7) * BANKB + $urandom_range(253, 255));
      else
        a = AW'($urandom_range(0, DEPTH-1));
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      be = WB'($urandom);
      exp_lat = ref_lat(int'(a));
      exp_d = w ? '0 : ref_read(int'(a));
      issue(w, a, d, be, rd, lat, ra);
      if (w) ref_write(int'(a), d, be);
      checks++;
      if (rd !== exp_d || lat !== exp_lat
          || ra !== (exp_lat == 1)) begin
        errors++;
        $display("FAIL rand%0d a=%h w=%b got %h lat %0d rdy %b exp %h lat %0d",
                 n, a, w, rd, lat, ra, exp_d, exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [8];
    logic [DW-1:0] exps [8];
    for (int k = 0; k < 8; k++) begin
      addrs[k] = AW'($urandom_range(0, 7) * BANKB + $urandom_range(0, 252));
      exps[k] = ref_read(int'(addrs[k]));
    end
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exps[k-1]) begin
          errors++;
          $display("FAIL b2b%0d got v%b %h exp v1 %h",
                   k-1, rsp_valid, rsp_rdata, exps[k-1]);
        end
      end
      if (k < 8) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d got %b exp 1", k, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addrs[k];
        @(negedge clk);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    int lat, cnt, seen;
    logic ra;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 11'h0FE;
    req_wdata = 32'h12345678;
    req_be    = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_second got ready %b exp 0", req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0
        || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got rdy %b v %b init %b exp 0 0 0",
               req_ready, rsp_valid, init_done);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 1000) begin
      if (rsp_valid) seen++;
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_rsp got %0d pulses exp 0", seen);
    end
    checks++;
    if (cnt !== 256 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear got %0d init %b exp 256 init 1",
               cnt, init_done);
    end
    ref_clear();
    issue(1'b0, 11'h0FE, '0, '0, rd, lat, ra);
    checks++;
    if (rd !== 32'h0 || lat !== 2) begin
      errors++;
      $display("FAIL mid_rd got %h lat %0d exp 0 lat 2", rd, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_byte_enable();
    test_crossing();
    test_top_edge();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
